// File: rtl/conv_host_seq_if.sv
// conv_host_seq_if: stream and conv-memory signals between the host sequencer
// and its neighbours.
//   s_*         byte stream in (raster-order image pixels)
//   m_*         byte stream out (conv results)
//   mi_*        conv input memory write port (packed 32-bit words)
//   mo_*        conv output memory read port (combinational read data)
//   conv_start  start pulse to conv; conv_done is its completion pulse
// The master modport is the sequencer side; slave is fabric + conv.
interface conv_host_seq_if #(parameter int DSIZE = 256);
  localparam int AW = $clog2(DSIZE) + 1;

  logic          s_valid;
  logic          s_ready;
  logic [7:0]    s_data;
  logic          m_valid;
  logic          m_ready;
  logic [7:0]    m_data;
  logic          m_last;
  logic [AW-1:0] mi_addr;
  logic [31:0]   mi_data;
  logic          mi_wr;
  logic [AW-1:0] mo_addr;
  logic [31:0]   mo_data;
  logic          conv_start;
  logic          conv_done;

  modport master (
    input  s_valid, s_data, m_ready, mo_data, conv_done,
    output s_ready, m_valid, m_data, m_last, mi_addr, mi_data, mi_wr,
           mo_addr, conv_start
  );

  modport slave (
    output s_valid, s_data, m_ready, mo_data, conv_done,
    input  s_ready, m_valid, m_data, m_last, mi_addr, mi_data, mi_wr,
           mo_addr, conv_start
  );
endinterface

// File: rtl/conv_host_seq.sv
// conv_host_seq: host-side sequencer for one conv instance.
// Loads an image byte stream into conv memory as packed words, kicks conv,
// waits for done, then streams out the strided result positions.
//   clk, rst_n      clock, synchronous active-low reset
//   cfg_*           job geometry, sampled on go in IDLE
//   go              job start (ignored while busy)
//   busy, finish    status; finish is a one-cycle pulse at job end
//   bus             conv_host_seq_if.master (streams + conv ports)
module conv_host_seq #(parameter int DSIZE = 256) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cfg_data_width,
  input  logic [7:0] cfg_data_height,
  input  logic [7:0] cfg_di_x_stop,
  input  logic [7:0] cfg_di_y_stop,
  input  logic [3:0] cfg_stride_x,
  input  logic [3:0] cfg_stride_y,
  input  logic       go,
  output logic       busy,
  output logic       finish,
  conv_host_seq_if.master bus
);
  localparam int AW = $clog2(DSIZE) + 1;

  typedef enum logic [2:0] {IDLE, LOAD, KICK, RUN, SETTLE, DRAIN, FIN} state_t;
  state_t state_q, state_d;

  logic [7:0]    width_q, xstop_q, ystop_q;
  logic [3:0]    sx_q, sy_q;
  logic [15:0]   n_q, cnt_q;
  logic [AW-1:0] row_step_q, row_q, widx_q;
  logic [31:0]   pack_q;
  logic          last_q;
  logic          mi_wr_q;
  logic [AW-1:0] mi_addr_q;
  logic [31:0]   mi_data_q;
  logic [7:0]    x_q, y_q;

  // Stride 0 behaves as stride 1.
  logic [3:0]  sx_eff, sy_eff;
  logic [15:0] n_full, rs_full;
  assign sx_eff  = (cfg_stride_x == 4'd0) ? 4'd1 : cfg_stride_x;
  assign sy_eff  = (cfg_stride_y == 4'd0) ? 4'd1 : cfg_stride_y;
  assign n_full  = 16'(cfg_data_width) * 16'(cfg_data_height);
  assign rs_full = 16'(sy_eff) * 16'(cfg_data_width);

  logic        s_hs, m_hs, last_byte, wr_now, at_xend, last_pos;
  logic [31:0] packed_w;
  assign s_hs      = bus.s_valid & bus.s_ready;
  assign m_hs      = bus.m_valid & bus.m_ready;
  assign last_byte = (cnt_q + 16'd1) == n_q;
  assign wr_now    = s_hs & ((cnt_q[1:0] == 2'd3) | last_byte);
  assign packed_w  = pack_q | (32'(bus.s_data) << {cnt_q[1:0], 3'b000});
  assign at_xend   = x_q == xstop_q;
  assign last_pos  = at_xend & (y_q == ystop_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go) state_d = LOAD;
      // last_q rises with the final mi_wr cycle, so leaving here lets it land.
      LOAD:    if (last_q) state_d = KICK;
      KICK:    state_d = RUN;
      RUN:     if (bus.conv_done) state_d = SETTLE;
      SETTLE:  state_d = DRAIN;
      DRAIN:   if (m_hs && last_pos) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      width_q    <= '0;
      xstop_q    <= '0;
      ystop_q    <= '0;
      sx_q       <= '0;
      sy_q       <= '0;
      n_q        <= '0;
      cnt_q      <= '0;
      row_step_q <= '0;
      row_q      <= '0;
      widx_q     <= '0;
      pack_q     <= '0;
      last_q     <= 1'b0;
      mi_wr_q    <= 1'b0;
      mi_addr_q  <= '0;
      mi_data_q  <= '0;
      x_q        <= '0;
      y_q        <= '0;
    end else begin
      state_q <= state_d;
      mi_wr_q <= 1'b0;
      case (state_q)
        IDLE: if (go) begin
          width_q    <= cfg_data_width;
          xstop_q    <= cfg_di_x_stop;
          ystop_q    <= cfg_di_y_stop;
          sx_q       <= sx_eff;
          sy_q       <= sy_eff;
          n_q        <= n_full;
          row_step_q <= rs_full[AW-1:0];
          cnt_q      <= '0;
          widx_q     <= '0;
          pack_q     <= '0;
          last_q     <= 1'b0;
          x_q        <= '0;
          y_q        <= '0;
          row_q      <= '0;
        end
        LOAD: if (s_hs) begin
          cnt_q <= cnt_q + 16'd1;
          if (last_byte) last_q <= 1'b1;
          if (wr_now) begin
            mi_wr_q   <= 1'b1;
            mi_addr_q <= {widx_q[AW-3:0], 2'b00};
            mi_data_q <= packed_w;
            widx_q    <= widx_q + 1'b1;
            pack_q    <= '0;
          end else begin
            pack_q <= packed_w;
          end
        end
        DRAIN: if (m_hs) begin
          // Position walk is incremental: row_q tracks width*y without a multiplier.
          if (last_pos) begin
            x_q   <= '0;
            y_q   <= '0;
            row_q <= '0;
          end else if (at_xend) begin
            x_q   <= '0;
            y_q   <= y_q + {4'd0, sy_q};
            row_q <= row_q + row_step_q;
          end else begin
            x_q <= x_q + {4'd0, sx_q};
          end
        end
        default: ;
      endcase
    end
  end

  assign busy           = state_q != IDLE;
  assign finish         = state_q == FIN;
  assign bus.s_ready    = (state_q == LOAD) && !last_q;
  assign bus.mi_wr      = mi_wr_q;
  assign bus.mi_addr    = mi_addr_q;
  assign bus.mi_data    = mi_data_q;
  assign bus.conv_start = state_q == KICK;
  assign bus.m_valid    = state_q == DRAIN;
  assign bus.m_last     = (state_q == DRAIN) && last_pos;
  assign bus.m_data     = (state_q == DRAIN) ? bus.mo_data[7:0] : 8'd0;
  assign bus.mo_addr    = AW'(x_q) + row_q;
endmodule

// File: tb/tb_conv_host_seq.sv
module tb_conv_host_seq;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] cfg_data_width, cfg_data_height, cfg_di_x_stop, cfg_di_y_stop;
  logic [3:0] cfg_stride_x, cfg_stride_y;
  logic       go;
  logic       busy, finish;

  conv_host_seq_if #(.DSIZE(256)) ifc ();

  conv_host_seq #(.DSIZE(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_data_width(cfg_data_width), .cfg_data_height(cfg_data_height),
    .cfg_di_x_stop(cfg_di_x_stop), .cfg_di_y_stop(cfg_di_y_stop),
    .cfg_stride_x(cfg_stride_x), .cfg_stride_y(cfg_stride_y),
    .go(go), .busy(busy), .finish(finish), .bus(ifc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [8:0] a; logic [31:0] d; } wr_t;
  typedef struct { logic [8:0] a; logic [7:0] d; logic last; } out_t;

  int checks = 0;
  int failures = 0;
  wr_t  exp_wr[$];
  out_t exp_out[$];
  logic [7:0] img [0:255];
  logic [7:0] mem [0:511];
  int   cur_n;
  int   starts = 0, fin_cnt = 0, outs = 0;
  int   s0, f0;
  int   mr_mode = 0;
  logic stall_q = 1'b0;
  logic [8:0] hold_a;
  logic [7:0] hold_d;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // Stand-in for conv's computation: each output byte is a fixed function of
  // the input byte at the same address.
  function automatic logic [7:0] fconv(input logic [7:0] b);
    return (b * 8'd3) + 8'd7;
  endfunction

  logic [7:0] fc;
  assign fc = fconv(mem[ifc.mo_addr]);
  assign ifc.mo_data = {8'hA5, ~fc, 8'h3C, fc};

  // Conv model: done pulse 0..3 cycles after entering RUN.
  initial begin
    ifc.conv_done = 1'b0;
    forever begin
      @(negedge clk);
      if (ifc.conv_start && rst_n) begin
        repeat ($urandom % 4) @(posedge clk);
        @(posedge clk); #1 ifc.conv_done = 1'b1;
        @(posedge clk); #1 ifc.conv_done = 1'b0;
      end
    end
  end

  // Output sink back-pressure.
  initial begin
    ifc.m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (mr_mode)
        0: ifc.m_ready = 1'b1;
        1: ifc.m_ready = ~ifc.m_ready;
        default: ifc.m_ready = 1'($urandom % 2);
      endcase
    end
  end

  // Monitor: writes, outputs, stall stability, pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ifc.mi_wr) begin
          for (int k = 0; k < 4; k++) mem[int'(ifc.mi_addr) + k] = ifc.mi_data[8*k +: 8];
          if (exp_wr.size() == 0) chk("wr_extra", 1, 0);
          else begin
            wr_t e;
            e = exp_wr.pop_front();
            chk("wr_addr", 32'(ifc.mi_addr), 32'(e.a));
            chk("wr_data", ifc.mi_data, e.d);
          end
        end
        if (ifc.m_valid) begin
          if (stall_q) begin
            chk("hold_addr", 32'(ifc.mo_addr), 32'(hold_a));
            chk("hold_data", 32'(ifc.m_data), 32'(hold_d));
          end
          stall_q = !ifc.m_ready;
          hold_a  = ifc.mo_addr;
          hold_d  = ifc.m_data;
          if (ifc.m_ready) begin
            outs++;
            if (exp_out.size() == 0) chk("out_extra", 1, 0);
            else begin
              out_t o;
              o = exp_out.pop_front();
              chk("out_addr", 32'(ifc.mo_addr), 32'(o.a));
              chk("out_data", 32'(ifc.m_data), 32'(o.d));
              chk("out_last", 32'(ifc.m_last), 32'(o.last));
            end
          end
        end else stall_q = 1'b0;
        if (ifc.conv_start) starts++;
        if (finish) fin_cnt++;
      end
    end
  end

  // Reference: packed writes and strided output walk from plain arithmetic.
  task automatic build(input int w, h, xs, ys, sx, sy, seqm);
    int n, sxe, sye;
    n = w * h;
    sxe = (sx == 0) ? 1 : sx;
    sye = (sy == 0) ? 1 : sy;
    cur_n = n;
    for (int i = 0; i < n; i++)
      img[i] = (seqm == 1) ? 8'(i) : (seqm == 2) ? 8'(i + 1) : 8'($urandom);
    exp_wr.delete();
    for (int b = 0; b < n; b += 4) begin
      wr_t e;
      e.a = 9'(b);
      e.d = 32'd0;
      for (int k = 0; k < 4; k++) if (b + k < n) e.d[8*k +: 8] = img[b + k];
      exp_wr.push_back(e);
    end
    exp_out.delete();
    for (int y = 0; y <= ys; y += sye)
      for (int x = 0; x <= xs; x += sxe) begin
        out_t o;
        o.a = 9'(x + w * y);
        o.d = fconv(img[x + w * y]);
        o.last = (x == xs) && (y == ys);
        exp_out.push_back(o);
      end
  endtask

  task automatic start_job(input int w, h, xs, ys, sx, sy, seqm);
    int i, guard;
    build(w, h, xs, ys, sx, sy, seqm);
    s0 = starts;
    f0 = fin_cnt;
    @(posedge clk); #1;
    cfg_data_width = 8'(w);  cfg_data_height = 8'(h);
    cfg_di_x_stop  = 8'(xs); cfg_di_y_stop   = 8'(ys);
    cfg_stride_x   = 4'(sx); cfg_stride_y    = 4'(sy);
    go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
    i = 0;
    guard = 0;
    while (i < cur_n && guard < 5000) begin
      guard++;
      if ($urandom % 4 == 0) ifc.s_valid = 1'b0;
      else begin
        ifc.s_valid = 1'b1;
        ifc.s_data  = img[i];
      end
      @(negedge clk);
      if (ifc.s_valid && ifc.s_ready) i++;
      @(posedge clk); #1;
    end
    ifc.s_valid = 1'b0;
    chk("bytes_accepted", 32'(i), 32'(cur_n));
    @(negedge clk);
    chk("s_ready_low", 32'(ifc.s_ready), 0);
  endtask

  task automatic finish_job(input bit poke_go);
    for (int c = 0; c < 4000 && fin_cnt == f0; c++) begin
      @(negedge clk);
      if (poke_go && c == 2) begin
        chk("busy_at_go", 32'(busy), 1);
        go = 1'b1;
        cfg_data_width = 8'd2; cfg_di_x_stop = 8'd0;
        @(negedge clk);
        go = 1'b0;
      end
    end
    @(negedge clk);
    chk("finish_cnt", 32'(fin_cnt - f0), 1);
    chk("start_cnt", 32'(starts - s0), 1);
    chk("wr_left", 32'(exp_wr.size()), 0);
    chk("out_left", 32'(exp_out.size()), 0);
    chk("idle_busy", 32'(busy), 0);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_finish"}, 32'(finish), 0);
    chk({tag, "_s_ready"}, 32'(ifc.s_ready), 0);
    chk({tag, "_m_valid"}, 32'(ifc.m_valid), 0);
    chk({tag, "_m_last"}, 32'(ifc.m_last), 0);
    chk({tag, "_m_data"}, 32'(ifc.m_data), 0);
    chk({tag, "_mi_wr"}, 32'(ifc.mi_wr), 0);
    chk({tag, "_mi_addr"}, 32'(ifc.mi_addr), 0);
    chk({tag, "_mi_data"}, ifc.mi_data, 0);
    chk({tag, "_mo_addr"}, 32'(ifc.mo_addr), 0);
    chk({tag, "_conv_start"}, 32'(ifc.conv_start), 0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'd0;
    rst_n = 1'b0; go = 1'b0;
    ifc.s_valid = 1'b0; ifc.s_data = 8'd0;
    cfg_data_width = 8'd0; cfg_data_height = 8'd0;
    cfg_di_x_stop = 8'd0; cfg_di_y_stop = 8'd0;
    cfg_stride_x = 4'd0; cfg_stride_y = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    mr_mode = 0; start_job(4, 4, 1, 1, 1, 1, 1); finish_job(0);
    mr_mode = 0; start_job(3, 3, 1, 1, 1, 1, 2); finish_job(0);
    mr_mode = 2; start_job(5, 5, 2, 2, 2, 2, 0); finish_job(0);
    mr_mode = 1; start_job(8, 8, 6, 6, 2, 3, 0); finish_job(0);
    mr_mode = 0; start_job(4, 3, 1, 0, 0, 1, 0); finish_job(0);
    mr_mode = 2; start_job(6, 5, 3, 2, 1, 1, 0); finish_job(1);
    mr_mode = 2; start_job(16, 16, 15, 15, 3, 5, 0); finish_job(0);

    // Reset in the middle of DRAIN: job abandoned, no finish.
    mr_mode = 1;
    start_job(8, 8, 7, 7, 1, 1, 0);
    begin
      int o0;
      o0 = outs;
      for (int c = 0; c < 2000 && outs < o0 + 3; c++) @(negedge clk);
      chk("reached_drain", 32'(outs >= o0 + 3), 1);
    end
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    exp_out.delete();
    exp_wr.delete();
    @(negedge clk);
    check_quiet("midrst");
    repeat (10) @(negedge clk);
    chk("midrst_no_finish", 32'(fin_cnt - f0), 0);

    for (int j = 0; j < 6; j++) begin
      int w, h, sx, sy, sxe, sye, xs, ys;
      w = 1 + $urandom % 16;
      h = 1 + $urandom % 16;
      sx = $urandom % 4;
      sy = $urandom % 4;
      sxe = (sx == 0) ? 1 : sx;
      sye = (sy == 0) ? 1 : sy;
      xs = sxe * ($urandom % ((w - 1) / sxe + 1));
      ys = sye * ($urandom % ((h - 1) / sye + 1));
      mr_mode = $urandom % 3;
      start_job(w, h, xs, ys, sx, sy, 0);
      finish_job(0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
